// File: rtl/median3x3_pkg.sv
// Shared post-processing definitions: default pixel width and the 3-input sort result.
package median3x3_pkg;

  localparam int MEDIAN_DATA_W = 16;

  typedef struct packed {
    logic [MEDIAN_DATA_W-1:0] max;
    logic [MEDIAN_DATA_W-1:0] med;
    logic [MEDIAN_DATA_W-1:0] min;
  } sort3_t;

endpackage

// File: rtl/median3x3_stream_sort3.sv
// Combinational 3-input unsigned sorter (max, med, min); ties may order either way.
module median_sort3
  import median3x3_pkg::*;
#(
  parameter int DATA_W = MEDIAN_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_c,
  output logic [DATA_W-1:0] o_max,
  output logic [DATA_W-1:0] o_med,
  output logic [DATA_W-1:0] o_min
);

  logic [DATA_W-1:0] w_hi;
  logic [DATA_W-1:0] w_lo;

  // Order a/b first, then place c against that pair.
  always_comb begin
    w_hi  = (i_a > i_b) ? i_a : i_b;
    w_lo  = (i_a > i_b) ? i_b : i_a;
    o_max = (w_hi > i_c) ? w_hi : i_c;
    o_min = (w_lo > i_c) ? i_c : w_lo;
    if (i_c > w_hi) begin
      o_med = w_hi;
    end else if (w_lo > i_c) begin
      o_med = w_lo;
    end else begin
      o_med = i_c;
    end
  end

endmodule

// File: rtl/median3x3_stream.sv
// Streaming 3x3 median filter: two line buffers, column sort, window reduction, final median.
module median3x3_stream
  import median3x3_pkg::*;
#(
  parameter int DATA_W = MEDIAN_DATA_W,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic              r_v1, r_v2, r_out_valid;
  logic              r_last1, r_last2, r_out_last;
  logic [DATA_W-1:0] r_out_data;

  // Line buffers: lb0 = previous row, lb1 = row before that.
  logic [DATA_W-1:0] r_lb0 [IMG_W];
  logic [DATA_W-1:0] r_lb1 [IMG_W];

  // Sorted window columns, index 0 is the newest.
  logic [DATA_W-1:0] r_wmax [3];
  logic [DATA_W-1:0] r_wmed [3];
  logic [DATA_W-1:0] r_wmin [3];

  logic [DATA_W-1:0] r_lo, r_mid, r_hi;

  logic              w_en, w_accept, w_x_last, w_y_last;
  logic [DATA_W-1:0] w_lb0_rd, w_lb1_rd;
  logic [DATA_W-1:0] w_col_max, w_col_med, w_col_min;
  logic [DATA_W-1:0] w_lo, w_lo_med, w_lo_min;
  logic [DATA_W-1:0] w_mid, w_mid_max, w_mid_min;
  logic [DATA_W-1:0] w_hi, w_hi_max, w_hi_med;
  logic [DATA_W-1:0] w_fin, w_fin_max, w_fin_min;
  logic              w_unused_ok;

  assign w_en      = ~r_out_valid | out_ready;
  assign in_ready  = w_en;
  assign w_accept  = in_valid & w_en;
  assign w_x_last  = (r_x == XW'(IMG_W - 1));
  assign w_y_last  = (r_y == YW'(IMG_H - 1));
  assign w_lb0_rd  = r_lb0[r_x];
  assign w_lb1_rd  = r_lb1[r_x];
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

  // Column sort: oldest row, previous row, incoming pixel.
  median_sort3 #(.DATA_W(DATA_W)) u_col (
    .i_a(w_lb1_rd), .i_b(w_lb0_rd), .i_c(in_data),
    .o_max(w_col_max), .o_med(w_col_med), .o_min(w_col_min)
  );

  // Window reductions: max of mins, median of meds, min of maxes.
  median_sort3 #(.DATA_W(DATA_W)) u_red_lo (
    .i_a(r_wmin[0]), .i_b(r_wmin[1]), .i_c(r_wmin[2]),
    .o_max(w_lo), .o_med(w_lo_med), .o_min(w_lo_min)
  );
  median_sort3 #(.DATA_W(DATA_W)) u_red_mid (
    .i_a(r_wmed[0]), .i_b(r_wmed[1]), .i_c(r_wmed[2]),
    .o_max(w_mid_max), .o_med(w_mid), .o_min(w_mid_min)
  );
  median_sort3 #(.DATA_W(DATA_W)) u_red_hi (
    .i_a(r_wmax[0]), .i_b(r_wmax[1]), .i_c(r_wmax[2]),
    .o_max(w_hi_max), .o_med(w_hi_med), .o_min(w_hi)
  );

  // Final median of the three reduced values.
  median_sort3 #(.DATA_W(DATA_W)) u_fin (
    .i_a(r_lo), .i_b(r_mid), .i_c(r_hi),
    .o_max(w_fin_max), .o_med(w_fin), .o_min(w_fin_min)
  );

  assign w_unused_ok = ^{w_lo_med, w_lo_min, w_mid_max, w_mid_min,
                         w_hi_max, w_hi_med, w_fin_max, w_fin_min};

  // Raster position counters, advancing only on accepted pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  // Line buffer update, read-before-write at the current column.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[r_x] <= w_lb0_rd;
      r_lb0[r_x] <= in_data;
    end
  end

  // Shift the sorted column into the 3-column window.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wmax[2] <= r_wmax[1];
      r_wmax[1] <= r_wmax[0];
      r_wmax[0] <= w_col_max;
      r_wmed[2] <= r_wmed[1];
      r_wmed[1] <= r_wmed[0];
      r_wmed[0] <= w_col_med;
      r_wmin[2] <= r_wmin[1];
      r_wmin[1] <= r_wmin[0];
      r_wmin[0] <= w_col_min;
    end
  end

  // Stage 2 data: reduced window values, held while stalled.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_lo  <= w_lo;
      r_mid <= w_mid;
      r_hi  <= w_hi;
    end
  end

  // Valid/last pipeline and output register; everything holds when en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_last1     <= 1'b0;
      r_last2     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_en) begin
      r_v1        <= w_accept & (r_x >= XW'(2)) & (r_y >= YW'(2));
      r_last1     <= w_accept & w_x_last & w_y_last;
      r_v2        <= r_v1;
      r_last2     <= r_last1;
      r_out_valid <= r_v2;
      r_out_last  <= r_last2;
      if (r_v2) begin
        r_out_data <= w_fin;
      end
    end
  end

endmodule

// File: tb/tb_median3x3_stream.sv
`timescale 1ns/1ps
// Directed bench for the 3x3 median stream on a 5x4 image.
module tb_median3x3_stream;

  localparam int DW   = 16;
  localparam int IW   = 5;
  localparam int IH   = 4;
  localparam int NPIX = IW * IH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_acc22 = -1;

  median3x3_stream #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Irregular test image whose medians differ from the window centres.
  int pat [20] = '{9, 1, 5, 3, 8,
                   2, 7, 4, 6, 0,
                   8, 3, 9, 1, 5,
                   4, 6, 2, 7, 3};

  function automatic int pix(input int mode, input int idx);
    int p, x, y;
    p = idx % NPIX;
    x = p % IW;
    y = p / IW;
    case (mode)
      0:       return 5 * y + x;
      1:       return (x == 2 && y == 2) ? 1000 : 0;
      2:       return 7;
      default: return pat[p];
    endcase
  endfunction

  // Output monitor plus handshake rules, sampled on the falling edge.
  typedef struct {int d; bit l; int c;} obs_t;
  obs_t          obs[$];
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic          prev_l = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", int'(in_ready), int'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), int'(prev_d));
        check("stall_last", int'(out_last), int'(prev_l));
      end
      if (out_valid && out_ready) obs.push_back('{int'(out_data), out_last, cyc});
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_l     = out_last;
    end
  end

  task automatic drive(input int mode, input bit bp, input bit rnd, input int n_acc);
    int idx;
    int guard;
    bit acc;
    idx   = 0;
    guard = 0;
    while (idx < n_acc && guard < 600) begin
      in_data  = DW'(pix(mode, idx));
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = bp ? ~out_ready : 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc && idx == 12 && mode == 0 && !bp) t_acc22 = cyc;
      @(posedge clk);
      #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    if (idx < n_acc) check("drive_timeout", idx, n_acc);
  endtask

  task automatic drain(input bit bp);
    repeat (12) begin
      out_ready = bp ? ~out_ready : 1'b1;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
  endtask

  task automatic compare(input string tag, input int n_exp, input int exp_d[12], input bit exp_l[12]);
    check({tag, "_count"}, obs.size(), n_exp);
    for (int k = 0; k < n_exp && k < obs.size(); k++) begin
      check($sformatf("%s_data[%0d]", tag, k), obs[k].d, exp_d[k]);
      check($sformatf("%s_last[%0d]", tag, k), int'(obs[k].l), int'(exp_l[k]));
    end
  endtask

  typedef struct {
    int mode;
    int nfr;
    bit bp;
    bit rnd;
    int n_exp;
    int exp_d[12];
    bit exp_l[12];
  } vec_t;

  vec_t vecs[6];

  initial begin
    // mode: 0 ramp 5y+x, 1 impulse, 2 constant 7, 3 irregular image
    vecs[0].mode = 0; vecs[0].nfr = 1; vecs[0].bp = 0; vecs[0].rnd = 0; vecs[0].n_exp = 6;
    vecs[0].exp_d = '{6, 7, 8, 11, 12, 13, 0, 0, 0, 0, 0, 0};
    vecs[0].exp_l = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[1].mode = 1; vecs[1].nfr = 1; vecs[1].bp = 0; vecs[1].rnd = 0; vecs[1].n_exp = 6;
    vecs[1].exp_d = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].exp_l = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[2].mode = 0; vecs[2].nfr = 1; vecs[2].bp = 1; vecs[2].rnd = 1; vecs[2].n_exp = 6;
    vecs[2].exp_d = '{6, 7, 8, 11, 12, 13, 0, 0, 0, 0, 0, 0};
    vecs[2].exp_l = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[3].mode = 2; vecs[3].nfr = 2; vecs[3].bp = 0; vecs[3].rnd = 0; vecs[3].n_exp = 12;
    vecs[3].exp_d = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
    vecs[3].exp_l = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    vecs[4].mode = 3; vecs[4].nfr = 1; vecs[4].bp = 0; vecs[4].rnd = 0; vecs[4].n_exp = 6;
    vecs[4].exp_d = '{5, 4, 5, 4, 6, 4, 0, 0, 0, 0, 0, 0};
    vecs[4].exp_l = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[5].mode = 3; vecs[5].nfr = 1; vecs[5].bp = 1; vecs[5].rnd = 1; vecs[5].n_exp = 6;
    vecs[5].exp_d = '{5, 4, 5, 4, 6, 4, 0, 0, 0, 0, 0, 0};
    vecs[5].exp_l = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_last", int'(out_last), 0);
    check("reset_in_ready", int'(in_ready), 1);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      obs.delete();
      drive(vecs[i].mode, vecs[i].bp, vecs[i].rnd, vecs[i].nfr * NPIX);
      drain(vecs[i].bp);
      compare($sformatf("vec%0d", i), vecs[i].n_exp, vecs[i].exp_d, vecs[i].exp_l);
      if (i == 0 && obs.size() > 0) check("latency_2_2", obs[0].c - t_acc22, 3);
      $display("vec %0d: mode %0d frames %0d bp %0d rnd %0d -> %0d outputs",
               i, vecs[i].mode, vecs[i].nfr, vecs[i].bp, vecs[i].rnd, obs.size());
    end

    // Reset mid-frame with a result in flight, then a clean ramp frame.
    obs.delete();
    drive(0, 1'b0, 1'b0, 13);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, NPIX);
    drain(1'b0);
    compare("abort", vecs[0].n_exp, vecs[0].exp_d, vecs[0].exp_l);
    $display("abort: reset after 13 accepts, then ramp -> %0d outputs", obs.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
